// File: rtl/vsi_pkg.sv
// Shared widths, phase offset and FSM encodings for the three-phase duty generator.
// Also holds the quarter-wave sine table generator used by the LUT.
package vsi_pkg;

    localparam int DUTY_W  = 10;
    localparam int SIN_W   = 12;
    localparam int IDX_W   = 10;
    localparam int M_W     = 9;
    localparam int M_ONE   = 256;
    localparam int P_SHIFT = 19;

    // round(2^w / 3): 2^w mod 3 is never 0, so adding 1 before the floor rounds
    function automatic longint ofs_for(input int w);
        return ((longint'(1) << w) + 1) / 3;
    endfunction

    localparam int     OFS_PH_W = 24;
    localparam longint OFS      = ofs_for(OFS_PH_W);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADV,
        S_ADDR,
        S_READ,
        S_MULT,
        S_STORE,
        S_COMMIT
    } state_t;

    typedef enum logic [1:0] {
        PH_A,
        PH_B,
        PH_C
    } phase_t;

    function automatic logic [SIN_W-2:0] quarter_sin(input int i);
        real r;
        r = 2047.0 * $sin(2.0 * 3.141592653589793 * real'(i) / 1024.0);
        return (SIN_W-1)'($rtoi(r + 0.5));
    endfunction

endpackage

// File: rtl/sine_quarter_lut.sv
// Full-wave sine lookup from a 257-entry quarter-wave table.
// Registered signed output, one cycle after the index is presented.
module sine_quarter_lut
    import vsi_pkg::*;
(
    input  logic                    clk,
    input  logic                    rstn,
    input  logic [IDX_W-1:0]        idx,
    output logic signed [SIN_W-1:0] s
);

    logic [SIN_W-2:0]        rom [0:256];
    logic [8:0]              qa;
    logic [SIN_W-2:0]        mag;
    logic signed [SIN_W-1:0] val;

    for (genvar i = 0; i <= 256; i++) begin : g_rom
        assign rom[i] = quarter_sin(i);
    end

    // odd quadrants read the table backwards, the lower half-wave is negated
    always_comb begin
        qa  = idx[8] ? 9'(9'd256 - {1'b0, idx[7:0]}) : {1'b0, idx[7:0]};
        mag = rom[qa];
        val = idx[9] ? -$signed({1'b0, mag}) : $signed({1'b0, mag});
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            s <= '0;
        end else begin
            s <= val;
        end
    end

endmodule

// File: rtl/vsi_duty_gen.sv
// Three-phase sinusoidal duty generator for the VSI dead-time PWM stage.
// One full sequential update per PWM sync edge, all phases committed together.
module vsi_duty_gen
    import vsi_pkg::*;
#(
    parameter int DUTY_MAX = 400,
    parameter int PH_W     = 24
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              en,
    input  logic [PH_W-1:0]   ftw,
    input  logic [M_W-1:0]    m,
    input  logic              pwm_sync,
    output logic [DUTY_W-1:0] d1,
    output logic [DUTY_W-1:0] d2,
    output logic [DUTY_W-1:0] d3,
    output logic              upd,
    output logic              overrun
);

    localparam int                 HALF   = DUTY_MAX >> 1;
    localparam logic [DUTY_W-1:0]  HALF_D = DUTY_W'(HALF);
    localparam logic [DUTY_W-1:0]  MAX_D  = DUTY_W'(DUTY_MAX - 1);
    localparam logic signed [31:0] HALF_S = 32'(HALF);
    localparam logic signed [31:0] MAX_S  = 32'(DUTY_MAX - 1);
    localparam logic [M_W-1:0]     M_SAT  = M_W'(M_ONE);
    localparam logic [PH_W-1:0]    OFS_W  = (PH_W == OFS_PH_W)
                                          ? PH_W'(OFS)
                                          : PH_W'(ofs_for(PH_W));

    state_t state;
    phase_t ph;

    logic                    sync_q;
    logic                    rise;
    logic [PH_W-1:0]         acc;
    logic [M_W-1:0]          m_l;
    logic                    en_l;
    logic [PH_W-1:0]         a_sel;
    logic [IDX_W-1:0]        idx;
    logic signed [SIN_W-1:0] s;
    logic signed [31:0]      prod;
    logic signed [31:0]      p;
    logic signed [31:0]      v;
    logic [DUTY_W-1:0]       v_sat;
    logic [DUTY_W-1:0]       sh_a;
    logic [DUTY_W-1:0]       sh_b;
    logic [DUTY_W-1:0]       sh_c;

    assign rise = pwm_sync & ~sync_q;

    always_comb begin
        a_sel = acc;
        unique case (ph)
            PH_B:    a_sel = acc + OFS_W;
            PH_C:    a_sel = acc - OFS_W;
            default: a_sel = acc;
        endcase
    end

    assign idx = a_sel[PH_W-1 -: IDX_W];

    sine_quarter_lut u_lut (
        .clk  (clk),
        .rstn (rstn),
        .idx  (idx),
        .s    (s)
    );

    // p >>> 19 floors toward -inf so the low rail lands exactly on 0
    always_comb begin
        prod = 32'(s) * $signed({{(32-M_W){1'b0}}, m_l}) * HALF_S;
        v    = HALF_S + (p >>> P_SHIFT);
        if (v < 0) begin
            v_sat = '0;
        end else if (v > MAX_S) begin
            v_sat = MAX_D;
        end else begin
            v_sat = v[DUTY_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state   <= S_IDLE;
            ph      <= PH_A;
            sync_q  <= 1'b0;
            acc     <= '0;
            m_l     <= '0;
            en_l    <= 1'b0;
            p       <= '0;
            sh_a    <= HALF_D;
            sh_b    <= HALF_D;
            sh_c    <= HALF_D;
            d1      <= HALF_D;
            d2      <= HALF_D;
            d3      <= HALF_D;
            upd     <= 1'b0;
            overrun <= 1'b0;
        end else begin
            sync_q <= pwm_sync;
            upd    <= 1'b0;
            if (rise && state != S_IDLE) begin
                overrun <= 1'b1;
            end
            unique case (state)
                S_IDLE: begin
                    if (rise) begin
                        state <= S_ADV;
                    end
                end
                S_ADV: begin
                    if (en) begin
                        acc <= acc + ftw;
                    end
                    m_l   <= (m > M_SAT) ? M_SAT : m;
                    en_l  <= en;
                    ph    <= PH_A;
                    state <= S_ADDR;
                end
                S_ADDR: state <= S_READ;
                S_READ: state <= S_MULT;
                S_MULT: begin
                    p     <= prod;
                    state <= S_STORE;
                end
                S_STORE: begin
                    unique case (ph)
                        PH_A:    sh_a <= v_sat;
                        PH_B:    sh_b <= v_sat;
                        default: sh_c <= v_sat;
                    endcase
                    if (ph == PH_C) begin
                        state <= S_COMMIT;
                    end else begin
                        ph    <= (ph == PH_A) ? PH_B : PH_C;
                        state <= S_ADDR;
                    end
                end
                S_COMMIT: begin
                    d1    <= en_l ? sh_a : HALF_D;
                    d2    <= en_l ? sh_b : HALF_D;
                    d3    <= en_l ? sh_c : HALF_D;
                    upd   <= 1'b1;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_vsi_duty_gen.sv
// Directed bench for vsi_duty_gen with a scoreboard of expected duty triples.
// Expected values come from an independent full-wave sine model.
module tb_vsi_duty_gen;

    localparam real         PI    = 3.141592653589793;
    localparam logic [23:0] OFS_M = 24'd5592405;

    typedef struct {
        int d1;
        int d2;
        int d3;
    } exp_t;

    logic        clk;
    logic        rstn;
    logic        en;
    logic [23:0] ftw;
    logic [8:0]  m;
    logic        pwm_sync;
    logic [9:0]  d1;
    logic [9:0]  d2;
    logic [9:0]  d3;
    logic        upd;
    logic        overrun;

    int          errors = 0;
    int          checks = 0;
    exp_t        sb[$];
    exp_t        last_e;
    exp_t        ref256;
    logic [23:0] acc_m;

    vsi_duty_gen dut (
        .clk      (clk),
        .rstn     (rstn),
        .en       (en),
        .ftw      (ftw),
        .m        (m),
        .pwm_sync (pwm_sync),
        .d1       (d1),
        .d2       (d2),
        .d3       (d3),
        .upd      (upd),
        .overrun  (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    function automatic int duty_m(input logic [23:0] a, input int mm, input bit e);
        int     idx;
        int     s;
        int     mc;
        real    r;
        longint p;
        longint v;
        if (!e) return 200;
        mc  = (mm > 256) ? 256 : mm;
        idx = int'(a[23:14]);
        r   = 2047.0 * $sin(2.0 * PI * real'(idx) / 1024.0);
        s   = (r >= 0.0) ? $rtoi(r + 0.5) : -$rtoi(0.5 - r);
        p   = longint'(s) * longint'(mc) * 200;
        v   = 200 + (p >>> 19);
        if (v < 0) v = 0;
        if (v > 399) v = 399;
        return int'(v);
    endfunction

    task automatic do_update(input string tag, input bit second_sync);
        exp_t        e;
        exp_t        got;
        int          lat;
        int          pulses;
        logic [23:0] ab;
        logic [23:0] ac;
        if (en) acc_m = acc_m + ftw;
        ab   = acc_m + OFS_M;
        ac   = acc_m - OFS_M;
        e.d1 = duty_m(acc_m, int'(m), en);
        e.d2 = duty_m(ab, int'(m), en);
        e.d3 = duty_m(ac, int'(m), en);
        sb.push_back(e);
        last_e = e;
        @(posedge clk); #1 pwm_sync = 1'b1;
        @(posedge clk); #1 pwm_sync = 1'b0;
        lat    = 0;
        pulses = 0;
        for (int n = 1; n <= 30; n++) begin
            @(posedge clk); #1;
            if (second_sync && n == 4) pwm_sync = 1'b1;
            if (second_sync && n == 5) pwm_sync = 1'b0;
            if (upd) begin
                pulses++;
                if (lat == 0) lat = n;
            end
        end
        check({tag, "_lat"}, lat, 14);
        check({tag, "_pulses"}, pulses, 1);
        got = sb.pop_front();
        check({tag, "_d1"}, int'(d1), got.d1);
        check({tag, "_d2"}, int'(d2), got.d2);
        check({tag, "_d3"}, int'(d3), got.d3);
    endtask

    initial begin
        int   d1_seq [4];
        int   pulses;
        d1_seq   = '{399, 200, 0, 200};
        rstn     = 1'b0;
        en       = 1'b0;
        ftw      = '0;
        m        = '0;
        pwm_sync = 1'b0;
        acc_m    = '0;
        repeat (3) @(posedge clk);
        #1 rstn = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check("rst_d1", int'(d1), 200);
        check("rst_d2", int'(d2), 200);
        check("rst_d3", int'(d3), 200);
        check("rst_upd", int'(upd), 0);
        check("rst_ovr", int'(overrun), 0);

        en  = 1'b1;
        ftw = 24'd0;
        m   = 9'd0;
        do_update("zero", 1'b0);

        ftw = 24'h40_0000;
        m   = 9'd256;
        for (int k = 0; k < 4; k++) begin
            do_update($sformatf("quad%0d", k), 1'b0);
            check($sformatf("quad%0d_d1c", k), int'(d1), d1_seq[k]);
            repeat (368) @(posedge clk);
        end

        ftw = 24'd12345;
        m   = 9'd256;
        do_update("pre_clamp", 1'b0);
        ftw = 24'd0;
        do_update("m256", 1'b0);
        ref256 = last_e;
        m = 9'd300;
        do_update("m300", 1'b0);
        check("clamp_d1", int'(d1), ref256.d1);
        check("clamp_d2", int'(d2), ref256.d2);
        check("clamp_d3", int'(d3), ref256.d3);

        en  = 1'b0;
        ftw = 24'd999;
        m   = 9'd256;
        do_update("park", 1'b0);
        en  = 1'b1;
        ftw = 24'h10_0000;
        m   = 9'd200;
        do_update("resume", 1'b0);
        check("pre_ovr", int'(overrun), 0);

        do_update("ovr", 1'b1);
        check("ovr_flag", int'(overrun), 1);

        ftw = 24'h40_0000;
        m   = 9'd256;
        @(posedge clk); #1 pwm_sync = 1'b1;
        @(posedge clk); #1 pwm_sync = 1'b0;
        repeat (6) @(posedge clk);
        #2 rstn = 1'b0;
        #1;
        check("mid_rst_d1", int'(d1), 200);
        check("mid_rst_d2", int'(d2), 200);
        check("mid_rst_d3", int'(d3), 200);
        check("mid_rst_upd", int'(upd), 0);
        check("mid_rst_ovr", int'(overrun), 0);
        pulses = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (upd) pulses++;
        end
        check("mid_rst_noupd", pulses, 0);
        check("mid_rst_hold", int'(d1), 200);
        rstn  = 1'b1;
        acc_m = '0;
        repeat (2) @(posedge clk);
        do_update("post_rst", 1'b0);
        check("post_rst_d1c", int'(d1), 399);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/vsi_duty_gen.md
# vsi_duty_gen

- Three-phase sinusoidal duty-cycle generator that feeds the `d1`/`d2`/`d3` inputs of the VSI dead-time PWM stage.
- Once per PWM period, triggered by that stage's `interrupt` output, it advances a phase accumulator.
- It computes three duties 120° apart from a sine table scaled by a modulation index, and presents them together with a one-cycle update strobe.
- It sits directly upstream of the VSI stage, on the same 100 MHz clock.

## Interface

Parameters:
- `DUTY_MAX`, 400: duty full scale in clocks (one PWM period); `HALF = DUTY_MAX >> 1`.
- `PH_W`, 24: phase accumulator width.

Ports:
- `clk`  in  1: system clock; all logic on rising edge.
- `rstn`  in  1: reset, asynchronous assert, active-low.
- `en`  in  1: 1 = modulate; 0 = park outputs at `HALF`.
- `ftw`  in  PH_W: phase increment per PWM period, unsigned.
- `m`  in  9: modulation index, Q1.8 unsigned; values above 256 are treated as 256.
- `pwm_sync`  in  1: connects to the VSI stage `interrupt`; a rising edge starts one update.
- `d1`, `d2`, `d3`  out  10: duties for phases A, B (+120°) and C (−120°).
- `upd`  out  1: one-cycle pulse when d1..d3 change.
- `overrun`  out  1: sticky; a sync edge arrived while busy. Cleared only by reset.

## Operation

- Edge detect: `rise = pwm_sync & ~sync_q`, with `sync_q` registered every cycle.
- State machine, one state per clock: IDLE → ADV → {ADDR, READ, MULT, STORE} × k=A,B,C → COMMIT → IDLE.
- IDLE: leaves only on `rise`.
- ADV:
  - If `en` is high, `acc += ftw` (mod 2^PH_W).
  - Latch `m_l = min(m, 256)` and `en_l = en`.
  - `ftw`, `m` and `en` are sampled only here.
- Per-phase index, taken from the top 10 bits:
  - A: `acc`.
  - B: `acc + OFS`.
  - C: `acc − OFS`.
  - `OFS = round(2^PH_W / 3)` (5592405 for PH_W=24).
- ADDR: drive the index to the LUT.
- READ: the LUT returns a signed 12-bit `s = round(2047·sin(2π·idx/1024))` (registered).
- MULT: `p = s · m_l · HALF`, signed, with width ≥ 30 bits.
- STORE: `v = HALF + (p >>> 19)`.
  - The shift is arithmetic, i.e. floor.
  - Saturate `v` to [0, DUTY_MAX − 1].
  - Write to the shadow register of phase k.
- COMMIT:
  - If `en_l` is set, copy the shadows to d1..d3.
  - Otherwise load all three with `HALF`.
  - Pulse `upd` in either case.
- The accumulator is held when `en` = 0. It is not cleared.
- A `rise` in any state other than IDLE is dropped, sets `overrun`, and does not restart the computation.
- `en` changing mid-computation has no effect until the next ADV.

## Timing

- Reset values:
  - d1 = d2 = d3 = `HALF`.
  - `upd` = 0, `overrun` = 0.
  - `acc` = 0, `sync_q` = 0, state IDLE.
- Let E0 be the clock edge at which IDLE sees `rise`.
  - d1..d3 change at edge E14.
  - `upd` is high for exactly one cycle, E14 → E15.
  - The next `rise` is accepted at E15 or later.
- All three duties change on the same edge. There are never partial updates.
- Reset asserted mid-computation:
  - Immediate return to reset values.
  - No `upd`.
  - Shadows are discarded.
- A `pwm_sync` held high causes exactly one update.
- Throughput: one update per 15 clocks, well below the 400-clock PWM period.

## Structure

- Package `vsi_pkg`:
  - `DUTY_W` = 10, `SIN_W` = 12, `IDX_W` = 10, `M_W` = 9.
  - Phase offset constant `OFS`.
  - FSM state enum.
- Sub-module `sine_quarter_lut`:
  - 257-entry quarter-wave ROM (indices 0..256) plus quadrant mirroring/negation.
  - 10-bit index in, registered signed 12-bit out, 1-cycle latency.
  - idx 256 → +2047, 768 → −2047, 0 and 512 → 0.
- Top level: edge detect, FSM, accumulator, one shared multiplier, shadows and output registers.

## Test plan

- Reset, no sync: d1..d3 = 200, `upd` = 0, `overrun` = 0 with DUTY_MAX = 400.
- `en`=1, `ftw`=0, `m`=0, one sync pulse: `upd` at E14; d1..d3 = 200.
- `en`=1, `ftw`=2^22, `m`=256, four sync pulses spaced 400 clocks:
  - d1 = 399, 200, 0, 200.
  - d2 and d3 match a bit-exact model of the index/LUT/floor formula.
- `m`=300 against `m`=256 at the same phase: identical outputs, confirming the clamp.
- Sync pulse at E5 of a running update: `overrun` goes to 1, exactly one `upd`, outputs equal the single-update case.
- Reset asserted at E7, released, then a sync pulse:
  - Outputs stay 200 through the reset, with no `upd`.
  - The next update starts from `acc` = 0; with `ftw`=2^22 it yields d1 = 399.
